// File: rtl/clct_zone_busy_gen_if.sv
// Sorter-side bundle for the CLCT zone busy generator: the sorter's best
// pattern/key/busy plus run-time settings in, busy mask and counters out.
interface clct_zone_busy_gen_if #(
  parameter int NZONE   = 7,
  parameter int MXKEYBX = 8,
  parameter int MXPATB  = 7,
  parameter int MXHOLDB = 4
);
  logic [MXPATB-1:0]  best_pat;
  logic [MXKEYBX-1:0] best_key;
  logic               best_bsy;
  logic [2:0]         hit_thresh;
  logic [MXHOLDB-1:0] hold_time;
  logic               trig_en;
  logic [NZONE-1:0]   bsy;
  logic               clct_accept;
  logic [2:0]         accept_zone;
  logic [15:0]        cnt_accept;
  logic [15:0]        cnt_blocked;

  // Sorter / stimulus side
  modport master (
    output best_pat, best_key, best_bsy, hit_thresh, hold_time, trig_en,
    input  bsy, clct_accept, accept_zone, cnt_accept, cnt_blocked
  );

  // Busy generator side
  modport slave (
    input  best_pat, best_key, best_bsy, hit_thresh, hold_time, trig_en,
    output bsy, clct_accept, accept_zone, cnt_accept, cnt_blocked
  );
endinterface

// File: rtl/clct_zone_busy_gen.sv
// Per-zone busy flag generator for the best-1-of-7 CLCT sorter. An accepted
// CLCT holds its 32-key zone (and an edge neighbour) busy for hold_time clocks.
module clct_zone_busy_gen #(
  parameter int NZONE   = 7,
  parameter int MXKEYB  = 5,
  parameter int MXKEYBX = 8,
  parameter int MXPATB  = 7,
  parameter int MXHOLDB = 4,
  parameter int EDGE    = 2
) (
  input logic                clock,
  input logic                reset_n,
  clct_zone_busy_gen_if.slave bus
);

  localparam logic [2:0]         LP_ZMAX = 3'(NZONE - 1);
  localparam logic [MXKEYB-1:0]  LP_KLO  = MXKEYB'(EDGE);
  localparam logic [MXKEYB-1:0]  LP_KHI  = MXKEYB'((1 << MXKEYB) - 1 - EDGE);
  localparam logic [MXHOLDB-1:0] LP_ONE  = MXHOLDB'(1);

  logic [2:0]                     w_hits;
  logic [2:0]                     w_zone;
  logic [MXKEYB-1:0]              w_key;
  logic                           w_accept;
  logic [NZONE-1:0]               w_load;
  logic [NZONE-1:0][MXHOLDB-1:0]  w_hc_dec;
  logic [NZONE-1:0][MXHOLDB-1:0]  w_hc_nxt;

  logic [NZONE-1:0][MXHOLDB-1:0]  r_hc;
  logic [NZONE-1:0]               r_bsy;
  logic                           r_clct_accept;
  logic [2:0]                     r_accept_zone;
  logic [15:0]                    r_cnt_accept;
  logic [15:0]                    r_cnt_blocked;

  assign w_hits = bus.best_pat[MXPATB-1 -: 3];
  assign w_zone = bus.best_key[MXKEYBX-1 -: 3];
  assign w_key  = bus.best_key[MXKEYB-1:0];

  // Accept qualification: enabled, not blocked, enough layers, legal zone
  always_comb begin
    w_accept = bus.trig_en && !bus.best_bsy && (w_hits >= bus.hit_thresh) &&
               (w_hits != 3'd0) && (w_zone <= LP_ZMAX);
  end

  // Zones to load: the originating zone plus the neighbour on a near edge
  always_comb begin
    w_load = '0;
    if (w_accept) begin
      for (int unsigned z = 0; z < NZONE; z++) begin
        if (3'(z) == w_zone)
          w_load[z] = 1'b1;
        if ((z > 0) && (3'(z - 1) == w_zone) && (w_key > LP_KHI))
          w_load[z] = 1'b1;
        if ((z < NZONE - 1) && (3'(z + 1) == w_zone) && (w_key < LP_KLO))
          w_load[z] = 1'b1;
      end
    end
  end

  // Next hold count: decrement toward zero; a load keeps whichever ends later,
  // so a retrigger can extend but never cut short an active hold
  always_comb begin
    w_hc_dec = '0;
    w_hc_nxt = '0;
    for (int unsigned z = 0; z < NZONE; z++) begin
      w_hc_dec[z] = (r_hc[z] != '0) ? (r_hc[z] - LP_ONE) : '0;
      w_hc_nxt[z] = w_hc_dec[z];
      if (w_load[z] && (bus.hold_time > w_hc_dec[z]))
        w_hc_nxt[z] = bus.hold_time;
    end
  end

  // Hold counters and busy flags; busy is taken from the next count so it
  // rises on the clock right after the accepting cycle
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_hc  <= '0;
      r_bsy <= '0;
    end else begin
      r_hc <= w_hc_nxt;
      for (int unsigned z = 0; z < NZONE; z++)
        r_bsy[z] <= (w_hc_nxt[z] != '0);
    end
  end

  // Accept strobe, last accepted zone and saturating event counters
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_clct_accept <= 1'b0;
      r_accept_zone <= '0;
      r_cnt_accept  <= '0;
      r_cnt_blocked <= '0;
    end else begin
      r_clct_accept <= w_accept;
      if (w_accept) begin
        r_accept_zone <= w_zone;
        if (r_cnt_accept != '1)
          r_cnt_accept <= r_cnt_accept + 16'd1;
      end
      if (bus.best_bsy && (r_cnt_blocked != '1))
        r_cnt_blocked <= r_cnt_blocked + 16'd1;
    end
  end

  assign bus.bsy         = r_bsy;
  assign bus.clct_accept = r_clct_accept;
  assign bus.accept_zone = r_accept_zone;
  assign bus.cnt_accept  = r_cnt_accept;
  assign bus.cnt_blocked = r_cnt_blocked;

endmodule

// File: tb/tb_clct_zone_busy_gen.sv
// Bench for clct_zone_busy_gen: directed scenarios plus randomized traffic
// against a cycle-number based reference model of the zone busy windows.
module tb_clct_zone_busy_gen;

  localparam int NZONE   = 7;
  localparam int MXKEYB  = 5;
  localparam int MXKEYBX = 8;
  localparam int MXPATB  = 7;
  localparam int MXHOLDB = 4;
  localparam int EDGE    = 2;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  clct_zone_busy_gen_if #(.NZONE(NZONE), .MXKEYBX(MXKEYBX), .MXPATB(MXPATB),
                          .MXHOLDB(MXHOLDB)) bus ();

  clct_zone_busy_gen #(.NZONE(NZONE), .MXKEYB(MXKEYB), .MXKEYBX(MXKEYBX),
                       .MXPATB(MXPATB), .MXHOLDB(MXHOLDB), .EDGE(EDGE)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: each zone is busy up to and including the cycle number
  // stored in busy_until; an accept extends it to (new cycle + hold - 1).
  int               cyc = 0;
  int               busy_until[NZONE] = '{default: -1};
  logic [NZONE-1:0] m_bsy = '0;
  logic             m_acc = 1'b0;
  logic [2:0]       m_zone = '0;
  int               m_cnt_acc = 0;
  int               m_cnt_blk = 0;

  always @(posedge clock) begin : model
    int hits, zone, key, lo, hi, end_c;
    bit ok;
    cyc++;
    hits = int'(bus.best_pat[6:4]);
    zone = int'(bus.best_key[7:5]);
    key  = int'(bus.best_key[4:0]);
    if (!reset_n) begin
      for (int z = 0; z < NZONE; z++) busy_until[z] = -1;
      m_acc = 1'b0; m_zone = '0; m_cnt_acc = 0; m_cnt_blk = 0;
    end else begin
      ok = bus.trig_en && !bus.best_bsy && (hits >= int'(bus.hit_thresh)) &&
           (hits > 0) && (zone < NZONE);
      m_acc = ok;
      if (ok) begin
        m_zone = 3'(zone);
        if (m_cnt_acc < 65535) m_cnt_acc++;
        if (bus.hold_time != 0) begin
          lo = zone; hi = zone;
          if (key < EDGE && zone > 0) lo = zone - 1;
          if (key > 31 - EDGE && zone < NZONE - 1) hi = zone + 1;
          end_c = cyc + int'(bus.hold_time) - 1;
          for (int z = lo; z <= hi; z++)
            if (busy_until[z] < end_c) busy_until[z] = end_c;
        end
      end
      if (bus.best_bsy && m_cnt_blk < 65535) m_cnt_blk++;
    end
    for (int z = 0; z < NZONE; z++) m_bsy[z] = (busy_until[z] >= cyc);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_idle();
    bus.trig_en  = 1'b0;
    bus.best_bsy = 1'b0;
    bus.best_pat = '0;
    bus.best_key = '0;
  endtask

  task automatic set_clct(input int zone, input int key, input int hits);
    bus.trig_en  = 1'b1;
    bus.best_bsy = 1'b0;
    bus.best_pat = {3'(hits), 4'($urandom)};
    bus.best_key = {3'(zone), 5'(key)};
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    checks++; if (bus.bsy !== 7'b0) begin errors++; $display("FAIL reset_bsy got=%b exp=0", bus.bsy); end
    checks++; if (bus.clct_accept !== 1'b0) begin errors++; $display("FAIL reset_accept got=%b exp=0", bus.clct_accept); end
    checks++; if (bus.accept_zone !== 3'd0) begin errors++; $display("FAIL reset_zone got=%0d exp=0", bus.accept_zone); end
    checks++; if (bus.cnt_accept !== 16'd0) begin errors++; $display("FAIL reset_cnt_acc got=%h exp=0", bus.cnt_accept); end
    checks++; if (bus.cnt_blocked !== 16'd0) begin errors++; $display("FAIL reset_cnt_blk got=%h exp=0", bus.cnt_blocked); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [6:0] exp_b;
    bus.hold_time = 4'd5; bus.hit_thresh = 3'd3;
    set_clct(3, 16, 4);
    tick();
    drive_idle();
    checks++; if (bus.accept_zone !== 3'd3) begin errors++; $display("FAIL basic_zone got=%0d exp=3", bus.accept_zone); end
    checks++; if (bus.cnt_accept !== 16'd1) begin errors++; $display("FAIL basic_cnt got=%h exp=1", bus.cnt_accept); end
    for (int c = 1; c <= 6; c++) begin
      exp_b = (c <= 5) ? 7'b0001000 : 7'b0;
      checks++; if (bus.bsy !== exp_b) begin errors++; $display("FAIL basic_bsy t+%0d got=%b exp=%b", c, bus.bsy, exp_b); end
      checks++; if (bus.clct_accept !== (c == 1)) begin errors++; $display("FAIL basic_strobe t+%0d got=%b exp=%b", c, bus.clct_accept, (c == 1)); end
      tick();
    end
  endtask

  task automatic test_edge();
    int         zn[6];
    int         ky[6];
    logic [6:0] mk[6];
    logic [6:0] exp_b;
    zn = '{2, 6, 0, 1, 4, 3};
    ky = '{1, 31, 0, 30, 2, 29};
    mk = '{7'b0000110, 7'b1000000, 7'b0000001, 7'b0000110, 7'b0010000, 7'b0001000};
    bus.hold_time = 4'd3; bus.hit_thresh = 3'd3;
    for (int i = 0; i < 6; i++) begin
      set_clct(zn[i], ky[i], 5);
      tick();
      drive_idle();
      for (int c = 1; c <= 4; c++) begin
        exp_b = (c <= 3) ? mk[i] : 7'b0;
        checks++;
        if (bus.bsy !== exp_b) begin
          errors++;
          $display("FAIL edge_bsy z=%0d k=%0d t+%0d got=%b exp=%b", zn[i], ky[i], c, bus.bsy, exp_b);
        end
        tick();
      end
    end
  endtask

  task automatic test_retrigger();
    int cnt0;
    cnt0 = m_cnt_acc;
    bus.hold_time = 4'd8; bus.hit_thresh = 3'd3;
    set_clct(4, 10, 6);
    tick();              // cycle t+1
    drive_idle();
    tick();              // t+2
    tick();              // t+3
    bus.hold_time = 4'd2;
    set_clct(4, 12, 6);
    tick();              // t+4
    drive_idle();
    checks++; if (bus.clct_accept !== 1'b1) begin errors++; $display("FAIL retrig_strobe got=%b exp=1", bus.clct_accept); end
    checks++; if (bus.cnt_accept !== 16'(cnt0 + 2)) begin errors++; $display("FAIL retrig_cnt got=%h exp=%h", bus.cnt_accept, 16'(cnt0 + 2)); end
    for (int c = 4; c <= 9; c++) begin
      checks++;
      if (bus.bsy[4] !== (c <= 8)) begin errors++; $display("FAIL retrig_bsy t+%0d got=%b exp=%b", c, bus.bsy[4], (c <= 8)); end
      tick();
    end
  endtask

  task automatic test_reject();
    int blk0;
    blk0 = m_cnt_blk;
    bus.hold_time = 4'd4; bus.hit_thresh = 3'd3;
    for (int i = 0; i < 26; i++) begin
      if (i < 5)       set_clct(1, 8, 2);                                  // too few hits
      else if (i < 10) begin set_clct(2, 8, 7); bus.trig_en = 1'b0; end    // disabled
      else if (i < 13) set_clct(7, 8, 7);                                  // illegal zone
      else if (i < 16) begin bus.hit_thresh = 3'd0; set_clct(3, 8, 0); end // zero hits
      else begin bus.hit_thresh = 3'd3; set_clct(5, 8, 7); bus.best_bsy = 1'b1; end
      tick();
      checks++; if (bus.clct_accept !== 1'b0) begin errors++; $display("FAIL reject_strobe i=%0d got=%b exp=0", i, bus.clct_accept); end
      checks++; if (bus.bsy !== 7'b0) begin errors++; $display("FAIL reject_bsy i=%0d got=%b exp=0", i, bus.bsy); end
    end
    drive_idle();
    checks++; if (bus.cnt_blocked !== 16'(blk0 + 10)) begin errors++; $display("FAIL reject_cnt_blk got=%0d exp=%0d", bus.cnt_blocked, blk0 + 10); end
  endtask

  task automatic test_reset_mid();
    bus.hold_time = 4'd15; bus.hit_thresh = 3'd3;
    set_clct(0, 5, 4);
    tick();              // t+1
    drive_idle();
    for (int c = 1; c <= 4; c++) begin
      checks++; if (bus.bsy !== 7'b0000001) begin errors++; $display("FAIL rstmid_bsy t+%0d got=%b exp=0000001", c, bus.bsy); end
      if (c < 4) tick();
    end
    reset_n = 1'b0;      // at t+4
    tick();              // t+5
    checks++; if (bus.bsy !== 7'b0) begin errors++; $display("FAIL rstmid_clear got=%b exp=0", bus.bsy); end
    checks++; if (bus.cnt_accept !== 16'd0) begin errors++; $display("FAIL rstmid_cnt_acc got=%h exp=0", bus.cnt_accept); end
    checks++; if (bus.cnt_blocked !== 16'd0) begin errors++; $display("FAIL rstmid_cnt_blk got=%h exp=0", bus.cnt_blocked); end
    reset_n = 1'b1;
    tick();
    bus.hold_time = 4'd2;
    set_clct(5, 10, 6);
    tick();
    drive_idle();
    checks++; if (bus.clct_accept !== 1'b1) begin errors++; $display("FAIL rstmid_reacc got=%b exp=1", bus.clct_accept); end
    checks++; if (bus.accept_zone !== 3'd5) begin errors++; $display("FAIL rstmid_zone got=%0d exp=5", bus.accept_zone); end
    checks++; if (bus.cnt_accept !== 16'd1) begin errors++; $display("FAIL rstmid_cnt got=%h exp=1", bus.cnt_accept); end
    checks++; if (bus.bsy !== 7'b0100000) begin errors++; $display("FAIL rstmid_bsy2 got=%b exp=0100000", bus.bsy); end
    tick(); tick();
    checks++; if (bus.bsy !== 7'b0) begin errors++; $display("FAIL rstmid_bsy_end got=%b exp=0", bus.bsy); end
  endtask

  task automatic test_random();
    int edge_keys[6];
    int key;
    edge_keys = '{0, 1, 2, 29, 30, 31};
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) bus.hold_time  = 4'($urandom);
      if ($urandom_range(0, 15) == 0) bus.hit_thresh = 3'($urandom);
      key = ($urandom_range(0, 2) == 0) ? edge_keys[$urandom_range(0, 5)] : int'($urandom_range(0, 31));
      bus.trig_en  = ($urandom_range(0, 3) != 0);
      bus.best_bsy = ($urandom_range(0, 7) == 0);
      bus.best_pat = 7'($urandom);
      bus.best_key = {3'($urandom_range(0, 7)), 5'(key)};
      tick();
      checks++; if (bus.bsy !== m_bsy) begin errors++; $display("FAIL rnd_bsy cyc=%0d got=%b exp=%b", cyc, bus.bsy, m_bsy); end
      checks++; if (bus.clct_accept !== m_acc) begin errors++; $display("FAIL rnd_strobe cyc=%0d got=%b exp=%b", cyc, bus.clct_accept, m_acc); end
      checks++; if (bus.accept_zone !== m_zone) begin errors++; $display("FAIL rnd_zone cyc=%0d got=%0d exp=%0d", cyc, bus.accept_zone, m_zone); end
      checks++; if (bus.cnt_accept !== 16'(m_cnt_acc)) begin errors++; $display("FAIL rnd_cnt_acc cyc=%0d got=%0d exp=%0d", cyc, bus.cnt_accept, m_cnt_acc); end
      checks++; if (bus.cnt_blocked !== 16'(m_cnt_blk)) begin errors++; $display("FAIL rnd_cnt_blk cyc=%0d got=%0d exp=%0d", cyc, bus.cnt_blocked, m_cnt_blk); end
    end
    drive_idle();
    repeat (20) tick();
  endtask

  task automatic test_saturate();
    int n1;
    bus.hold_time = 4'd0; bus.hit_thresh = 3'd1;
    set_clct(2, 5, 7);
    n1 = 65534 - m_cnt_acc;
    repeat (n1) tick();
    checks++; if (bus.cnt_accept !== 16'hFFFE) begin errors++; $display("FAIL sat_pre got=%h exp=FFFE", bus.cnt_accept); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.cnt_accept !== 16'hFFFF) begin errors++; $display("FAIL sat_cnt i=%0d got=%h exp=FFFF", i, bus.cnt_accept); end
      checks++; if (bus.clct_accept !== 1'b1) begin errors++; $display("FAIL sat_strobe i=%0d got=%b exp=1", i, bus.clct_accept); end
      checks++; if (bus.bsy !== 7'b0) begin errors++; $display("FAIL sat_bsy_hold0 i=%0d got=%b exp=0", i, bus.bsy); end
    end
    drive_idle();
    tick();
  endtask

  initial begin
    drive_idle();
    bus.hit_thresh = 3'd3;
    bus.hold_time  = 4'd0;
    test_reset();
    test_basic();
    test_edge();
    test_retrigger();
    test_reject();
    test_reset_mid();
    test_random();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
